im_loader: RTL and testbench
============================

Name: im_loader

Overview:
- Boot-time writer for the instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit MIPS instruction words.
- Writes each word to consecutive word-aligned IM addresses, starting at 0.
- Holds the CPU in stall until the image is loaded; then releases it so fetch begins at address 0.

Parameters:
- ADDR_W, 5: IM word-index width; depth = 2^ADDR_W = 32 words.
- LEN_W, 6: width of the word-count input (ADDR_W+1).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load, honoured only in IDLE or DONE
- len  in  LEN_W  number of words to load, sampled on start
- byte_valid  in  1  stream byte available
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- im_we  out  1  IM write strobe, one cycle per word
- im_addr  out  32  IM byte address, word aligned: {word_idx, 2'b00}, upper bits zero
- im_wdata  out  32  assembled instruction word
- cpu_hold  out  1  stall the CPU/PC while high
- done  out  1  load complete, level
- err  out  1  load error, level; cleared on the next accepted start

Behaviour:
- Reset values (asynchronous, rst_n low):
  - state=IDLE; byte_ready=0; im_we=0; im_addr=0; im_wdata=0.
  - cpu_hold=1; done=0; err=0; byte counter=0; word_idx=0.
- States:
  - IDLE: cpu_hold=1. On start:
    - len==0 -> DONE with no writes.
    - len>2^ADDR_W -> DONE with err=1, no writes.
    - Otherwise latch len, clear counters -> LOAD.
  - LOAD: byte_ready=1.
    - A byte is accepted only when byte_valid&&byte_ready.
    - Accepted byte k (0..3) goes to bits [31-8k:24-8k], so the first byte is the MSB.
    - byte_valid low stalls with no state change.
    - After the 4th accepted byte -> WRITE.
  - WRITE: byte_ready=0; im_we=1 for exactly this cycle.
    - im_addr=word_idx<<2; im_wdata=assembled word.
    - Next cycle: if word_idx==len-1 -> DONE (or CSUM when the option is enabled); else word_idx++ and -> LOAD.
  - DONE: done=1; cpu_hold=0; byte_ready=0. Stays until start, which is re-evaluated as in IDLE.
- Latency and throughput:
  - im_we asserts the cycle after the 4th byte is accepted.
  - Minimum 5 cycles per word.
- Boundary conditions:
  - start in LOAD/WRITE is ignored.
  - len==2^ADDR_W is legal; the last write goes to im_addr=0x7C.
  - word_idx never wraps.
- Reset mid-load: returns to IDLE with cpu_hold=1. Already-written IM words are not erased. Any partial word is discarded.
- im_addr and im_wdata hold their last values outside WRITE.

Optional Feature:
- Macro: IM_LOADER_CSUM_EN.
- When defined:
  - A running XOR of all accepted image bytes is kept.
  - After the last WRITE, the FSM enters CSUM with byte_ready=1 and accepts exactly one checksum byte.
  - Mismatch sets err=1.
  - Either way the FSM then moves to DONE.
- When undefined: no CSUM state and no checksum logic; the last WRITE goes directly to DONE.

Decomposition:
- Package im_loader_pkg:
  - state encoding (IDLE, LOAD, WRITE, CSUM, DONE);
  - IM_DEPTH=32;
  - BYTES_PER_WORD=4.
- Sub-module im_byte_asm: a 2-bit byte counter plus a 32-bit shift register with a word_full flag. The FSM stays in im_loader.

Test Plan:
- Reset: assert rst_n=0 mid-run -> cpu_hold=1, done=0, err=0, im_we=0, byte_ready=0 immediately, without waiting for a clock edge.
- Two-word load: start, len=2, bytes 20 01 00 08 34 02 00 0C with no gaps:
  - one-cycle im_we at addr 0x0 data 0x20010008;
  - one-cycle im_we at addr 0x4 data 0x3402000C;
  - then done=1, cpu_hold=0.
- Stalled stream: same image with byte_valid low for 3 cycles between every byte -> identical writes and data, no extra im_we pulses.
- Bounds:
  - len=0 -> DONE next cycle with no writes.
  - len=33 -> err=1, done=1, no writes.
  - len=32 -> last write at 0x7C.
- Reset mid-load: deassert rst_n after 6 bytes of a 2-word load -> only addr 0x0 was written. A new start, len=1 with bytes AD 02 00 0A, writes 0xAD02000A at addr 0x0.
- With IM_LOADER_CSUM_EN, image 20 01 00 08:
  - checksum 0x29 -> err=0;
  - checksum 0x00 -> err=1;
  - done=1 in both cases.

Source files
------------

// File: rtl/im_loader_pkg.sv
// im_loader_pkg
// Shared definitions for the instruction-memory boot loader.
//   IM_DEPTH       : default instruction memory depth in words
//   BYTES_PER_WORD : stream bytes assembled into one instruction word
//   state_t        : loader FSM encoding (CSUM is only reachable when the
//                    IM_LOADER_CSUM_EN build option is defined)
package im_loader_pkg;

  localparam int IM_DEPTH       = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/im_byte_asm.sv
// im_byte_asm
// Assembles big-endian 32-bit words from a byte stream. The first accepted
// byte of a word ends up in bits [31:24], the fourth in bits [7:0].
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   clear      : synchronous clear of counter, shift register and full flag
//   accept     : a byte is taken this cycle
//   byte_data  : the byte being taken
//   word       : assembled word (valid while word_full is high)
//   word_last  : the next accepted byte completes the word
//   word_full  : high for exactly the cycle after the 4th byte is taken
module im_byte_asm
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_last,
  output logic        word_full
);

  logic [1:0]  cnt_reg;
  logic [31:0] shift_reg;
  logic        full_reg;

  assign word_last = (cnt_reg == 2'(BYTES_PER_WORD - 1));
  assign word      = shift_reg;
  assign word_full = full_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= 2'd0;
      shift_reg <= 32'd0;
      full_reg  <= 1'b0;
    end else if (clear) begin
      cnt_reg   <= 2'd0;
      shift_reg <= 32'd0;
      full_reg  <= 1'b0;
    end else begin
      full_reg <= accept && word_last;
      if (accept) begin
        // Shifting left makes the earliest byte the MSB after four bytes;
        // the 2-bit counter wraps to zero for the next word.
        shift_reg <= {shift_reg[23:0], byte_data};
        cnt_reg   <= cnt_reg + 2'd1;
      end
    end
  end

endmodule

// File: rtl/im_loader.sv
// im_loader
// Boot-time writer for the instruction memory. Takes a byte stream over a
// valid/ready handshake, assembles big-endian 32-bit instruction words and
// writes them to consecutive word addresses starting at 0, holding the CPU
// in stall until the image has been loaded.
// Build option: IM_LOADER_CSUM_EN adds a trailing checksum byte (XOR of all
// image bytes) after the last word; a mismatch sets err.
// Ports:
//   clk, rst_n         : clock (rising edge), asynchronous active-low reset
//   start, len         : one-cycle load request and word count (sampled on start)
//   byte_valid/ready   : stream handshake, byte_data is the payload
//   im_we/addr/wdata   : IM write port (byte address, word aligned)
//   cpu_hold           : stall CPU/PC while high
//   done, err          : load-complete and load-error levels
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = $clog2(IM_DEPTH),
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             im_we,
  output logic [31:0]      im_addr,
  output logic [31:0]      im_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             err
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] word_idx_reg, word_idx_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic              err_reg, err_next;
  logic [31:0]       addr_hold_reg, wdata_hold_reg;
  logic              asm_clear;
  logic              accept;
  logic [31:0]       asm_word;
  logic              word_last;
  logic              word_full;
  logic [31:0]       addr_live;
`ifdef IM_LOADER_CSUM_EN
  logic [7:0]        csum_reg, csum_next;
`endif

`ifdef IM_LOADER_CSUM_EN
  assign byte_ready = (state_reg == ST_LOAD) || (state_reg == ST_CSUM);
`else
  assign byte_ready = (state_reg == ST_LOAD);
`endif
  assign accept   = byte_valid && byte_ready;
  assign done     = (state_reg == ST_DONE);
  assign cpu_hold = (state_reg != ST_DONE);
  assign err      = err_reg;

  assign addr_live = {{(32-ADDR_W-2){1'b0}}, word_idx_reg, 2'b00};

  // word_full is high exactly during WRITE, so it doubles as the write strobe.
  // Outside that cycle the port shows the last written address/data.
  assign im_we    = word_full;
  assign im_addr  = word_full ? addr_live : addr_hold_reg;
  assign im_wdata = word_full ? asm_word  : wdata_hold_reg;

  im_byte_asm u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (asm_clear),
    .accept    (accept && (state_reg == ST_LOAD)),
    .byte_data (byte_data),
    .word      (asm_word),
    .word_last (word_last),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      word_idx_reg   <= '0;
      len_reg        <= '0;
      err_reg        <= 1'b0;
      addr_hold_reg  <= 32'd0;
      wdata_hold_reg <= 32'd0;
`ifdef IM_LOADER_CSUM_EN
      csum_reg       <= 8'd0;
`endif
    end else begin
      state_reg    <= state_next;
      word_idx_reg <= word_idx_next;
      len_reg      <= len_next;
      err_reg      <= err_next;
`ifdef IM_LOADER_CSUM_EN
      csum_reg     <= csum_next;
`endif
      if (word_full) begin
        addr_hold_reg  <= addr_live;
        wdata_hold_reg <= asm_word;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    word_idx_next = word_idx_reg;
    len_next      = len_reg;
    err_next      = err_reg;
    asm_clear     = 1'b0;
`ifdef IM_LOADER_CSUM_EN
    csum_next     = csum_reg;
`endif
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          err_next      = 1'b0;
          asm_clear     = 1'b1;
          word_idx_next = '0;
`ifdef IM_LOADER_CSUM_EN
          csum_next     = 8'd0;
`endif
          if (len == '0) begin
            state_next = ST_DONE;
          end else if (len > LEN_W'(DEPTH)) begin
            err_next   = 1'b1;
            state_next = ST_DONE;
          end else begin
            len_next   = len;
            state_next = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (byte_valid) begin
`ifdef IM_LOADER_CSUM_EN
          csum_next = csum_reg ^ byte_data;
`endif
          if (word_last) begin
            state_next = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        // len_reg is at least 1 here, so len_reg-1 cannot underflow and
        // word_idx stops at the last word instead of wrapping.
        if ({1'b0, word_idx_reg} == len_reg - LEN_W'(1)) begin
`ifdef IM_LOADER_CSUM_EN
          state_next = ST_CSUM;
`else
          state_next = ST_DONE;
`endif
        end else begin
          word_idx_next = word_idx_reg + ADDR_W'(1);
          state_next    = ST_LOAD;
        end
      end
`ifdef IM_LOADER_CSUM_EN
      ST_CSUM: begin
        if (byte_valid) begin
          if (byte_data != csum_reg) begin
            err_next = 1'b1;
          end
          state_next = ST_DONE;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_im_loader.sv
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  len = 6'd0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  im_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [31:0] ea[$];
  logic [31:0] ed[$];
  logic [7:0]  bq[$];

  // Every cycle with im_we high is logged, so a stretched or extra pulse
  // shows up as an extra write.
  always @(negedge clk) begin
    if (im_we) begin
      wq_addr.push_back(im_addr);
      wq_data.push_back(im_wdata);
    end
  end

  typedef struct {
    logic [5:0]  len;
    int          gap;
    int          nwords;
    logic [63:0] image;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    wq_addr.delete(); wq_data.delete();
    ea.delete(); ed.delete(); bq.delete();
  endtask

  task automatic do_start(input logic [5:0] l);
    @(posedge clk); #1;
    start = 1'b1; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic got;
    got = 1'b0;
    for (int g = 0; g < gap; g++) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = byte_ready;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    if (!got) chk("byte_accept_timeout", {31'd0, got}, 32'd1);
  endtask

  // Sends the queued image; poke_at inserts a start pulse (len=0) before that
  // byte index, which must be ignored while loading.
  task automatic send_image(input int gap, input int poke_at);
    logic [7:0] x;
    x = 8'd0;
    for (int k = 0; k < bq.size(); k++) begin
      if (k == poke_at) begin
        start = 1'b1; len = 6'd0;
        @(posedge clk); #1;
        start = 1'b0;
      end
      send_byte(bq[k], gap);
      x = x ^ bq[k];
    end
`ifdef IM_LOADER_CSUM_EN
    send_byte(x, gap);
`endif
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_wait", {31'd0, seen}, 32'd1);
  endtask

  task automatic push_word(input int w, input logic [31:0] d);
    ea.push_back(32'(w * 4));
    ed.push_back(d);
    bq.push_back(d[31:24]); bq.push_back(d[23:16]);
    bq.push_back(d[15:8]);  bq.push_back(d[7:0]);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwrites"}, 32'(wq_addr.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < wq_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wq_addr[i], ea[i]);
      chk($sformatf("%s_data%0d", tag, i), wq_data[i], ed[i]);
    end
  endtask

  initial begin
    vecs[0] = '{6'd2,  0, 2, 64'h20010008_3402000C, 1'b0};
    vecs[1] = '{6'd2,  3, 2, 64'h20010008_3402000C, 1'b0};
    vecs[2] = '{6'd0,  0, 0, 64'h0, 1'b0};
    vecs[3] = '{6'd33, 0, 0, 64'h0, 1'b1};
    vecs[4] = '{6'd1,  1, 1, 64'hAD02000A_00000000, 1'b0};

    // Reset state, checked while rst_n is low and before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_im_we", {31'd0, im_we}, 32'd0);
    chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_im_addr", im_addr, 32'd0);
    chk("rst_im_wdata", im_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      logic [63:0] img;
      clear_logs();
      img = vecs[v].image;
      for (int w = 0; w < vecs[v].nwords; w++) push_word(w, img[63-32*w -: 32]);
      do_start(vecs[v].len);
      if (vecs[v].nwords == 0) begin
        chk($sformatf("v%0d_done_next", v), {31'd0, done}, 32'd1);
      end else begin
        chk($sformatf("v%0d_hold_loading", v), {31'd0, cpu_hold}, 32'd1);
        chk($sformatf("v%0d_ready_loading", v), {31'd0, byte_ready}, 32'd1);
        send_image(vecs[v].gap, -1);
        wait_done();
      end
      repeat (3) @(negedge clk);
      check_writes($sformatf("v%0d", v));
      chk($sformatf("v%0d_err", v), {31'd0, err}, {31'd0, vecs[v].exp_err});
      chk($sformatf("v%0d_done", v), {31'd0, done}, 32'd1);
      chk($sformatf("v%0d_cpu_hold", v), {31'd0, cpu_hold}, 32'd0);
      chk($sformatf("v%0d_byte_ready", v), {31'd0, byte_ready}, 32'd0);
      $display("vec %0d: len=%0d gap=%0d writes=%0d err=%0b done=%0b",
               v, vecs[v].len, vecs[v].gap, wq_addr.size(), err, done);
    end

    // Full-depth load; a start pulse mid-load must be ignored.
    clear_logs();
    for (int i = 0; i < 32; i++) begin
      logic [7:0] b;
      b = 8'(i);
      push_word(i, {b, 8'h5A, ~b, 8'(i * 3)});
    end
    do_start(6'd32);
    send_image(0, 41);
    wait_done();
    repeat (3) @(negedge clk);
    check_writes("len32");
    if (wq_addr.size() == 32) chk("len32_last_addr", wq_addr[31], 32'h7C);
    else chk("len32_last_addr_missing", 32'(wq_addr.size()), 32'd32);
    chk("len32_err", {31'd0, err}, 32'd0);
    $display("len32: writes=%0d last_addr=0x%08h done=%0b", wq_addr.size(), im_addr, done);

    // Asynchronous reset while in DONE with err set and IM outputs non-zero.
    do_start(6'd33);
    chk("len33_err_before_rst", {31'd0, err}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_im_addr", im_addr, 32'd0);
    chk("arst_im_wdata", im_wdata, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    $display("async reset in DONE: cpu_hold=%0b done=%0b err=%0b", cpu_hold, done, err);

    // Reset after 6 bytes of a 2-word load: only word 0 was written.
    clear_logs();
    push_word(0, 32'h20010008);
    push_word(1, 32'h3402000C);
    do_start(6'd2);
    for (int k = 0; k < 6; k++) send_byte(bq[k], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("midrst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("midrst_im_we", {31'd0, im_we}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    void'(ea.pop_back()); void'(ed.pop_back());
    check_writes("midrst");
    $display("mid-load reset: writes=%0d", wq_addr.size());

    // Reload after the reset: partial word must not leak into the new word.
    clear_logs();
    push_word(0, 32'hAD02000A);
    do_start(6'd1);
    send_image(0, -1);
    wait_done();
    repeat (2) @(negedge clk);
    check_writes("reload");
    chk("reload_err", {31'd0, err}, 32'd0);
    $display("reload: writes=%0d data=0x%08h", wq_addr.size(), im_wdata);

`ifdef IM_LOADER_CSUM_EN
    for (int c = 0; c < 2; c++) begin
      logic [7:0] cs;
      cs = (c == 0) ? 8'h29 : 8'h00;
      clear_logs();
      push_word(0, 32'h20010008);
      do_start(6'd1);
      for (int k = 0; k < 4; k++) send_byte(bq[k], 0);
      send_byte(cs, 0);
      wait_done();
      repeat (2) @(negedge clk);
      check_writes($sformatf("csum%0d", c));
      chk($sformatf("csum%0d_err", c), {31'd0, err}, (c == 0) ? 32'd0 : 32'd1);
      chk($sformatf("csum%0d_done", c), {31'd0, done}, 32'd1);
      $display("csum byte 0x%02h: err=%0b done=%0b", cs, err, done);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
